// File: rtl/stage3_pkg.sv
// Shared types for the memory-access stage: request record, FSM states, legality rule.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package stage3_pkg;

    localparam int WORD_BYTES = 4;
    localparam int REQ_ADDR_W = 9;

    typedef struct packed {
        logic                  instr;
        logic [REQ_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
        logic [3:0]            wstrb;
    } mem_req_t;

    typedef enum logic {
        ST_RUN,
        ST_FAULT
    } st_e;

    // Misaligned word access, or an instruction fetch that tries to store.
    function automatic logic req_illegal(input mem_req_t r);
        return (r.addr[1:0] != 2'b00) || (r.instr && (r.wstrb != 4'b0000));
    endfunction

endpackage

// File: rtl/mem_stage3_req_fifo.sv
// Small circular request queue; pop data is the registered head entry.
// Latency: pushed entry is visible at the head one cycle after the push edge.
// Backpressure: caller must not push when full unless popping in the same cycle.
module req_fifo
    import stage3_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  mem_req_t push_dat,
    input  logic     pop,
    output mem_req_t pop_dat,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    mem_req_t             store_q [DEPTH];
    mem_req_t             store_d [DEPTH];
    logic     [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic     [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic     [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        store_d  = store_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            store_d[wr_ptr_q] = push_dat;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload needs no reset: it is only observed while the count says valid.
    always_ff @(posedge clk) begin
        store_q <= store_d;
    end

    assign pop_dat = store_q[rd_ptr_q];
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);

endmodule

// File: rtl/mem_stage3.sv
// Memory-access stage: queues requests and services them from a byte-writable word RAM.
// Latency: accept at edge N, response valid after edge N+1 when queue empty and slot free.
// Backpressure: head issues only when the response slot frees; req_ready drops when queue full.
module mem_stage3
    import stage3_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int DEPTH_WORDS = 128,
    parameter int QDEPTH      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_instr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_instr,
    output logic              fault,
    output logic [15:0]       req_count
);

    localparam int IDX_W = ADDR_W - 2;

    logic [31:0] mem [DEPTH_WORDS];

    mem_req_t   in_req, head;
    logic       q_full, q_empty;
    logic       issue, accept, illegal, push;
    logic       head_is_write;
    logic [IDX_W-1:0] head_idx;

    st_e         st_q, st_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_instr_q, rsp_instr_d;
    logic [15:0] req_count_q, req_count_d;

    assign in_req = '{instr: req_instr, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};

    assign issue         = !q_empty && (!rsp_valid_q || rsp_ready);
    assign req_ready     = (st_q == ST_RUN) && (!q_full || issue);
    assign accept        = req_valid && req_ready;
    assign illegal       = req_illegal(in_req);
    assign push          = accept && !illegal;
    assign head_is_write = (head.wstrb != 4'b0000);
    assign head_idx      = IDX_W'(head.addr / WORD_BYTES);

    req_fifo #(
        .DEPTH(QDEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .push_dat(in_req),
        .pop     (issue),
        .pop_dat (head),
        .full    (q_full),
        .empty   (q_empty)
    );

    always_comb begin
        st_d        = st_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        rsp_rdata_d = rsp_rdata_q;
        rsp_instr_d = rsp_instr_q;
        req_count_d = req_count_q + 16'(accept);
        if (accept && illegal) begin
            st_d = ST_FAULT;
        end
        // Read data is sampled before this edge's write, so a read sees the old word.
        if (issue) begin
            rsp_valid_d = 1'b1;
            rsp_instr_d = head.instr;
            rsp_rdata_d = head_is_write ? 32'h0 : mem[head_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q        <= ST_RUN;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_instr_q <= 1'b0;
            req_count_q <= 16'h0;
        end else begin
            st_q        <= st_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_instr_q <= rsp_instr_d;
            req_count_q <= req_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && issue && head_is_write) begin
            for (int k = 0; k < 4; k++) begin
                if (head.wstrb[k]) begin
                    mem[head_idx][8*k +: 8] <= head.wdata[8*k +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_instr = rsp_instr_q;
    assign fault     = (st_q == ST_FAULT);
    assign req_count = req_count_q;

endmodule
